// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit controller: op codes,
// operation latencies, FSM state encoding and the long-op decode helper.
// Optional divider support is selected with the MDU_DIV_EN macro.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2
    } mdu_state_e;

    localparam logic [3:0] MUL_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES = 4'd10;

    // True for ops that occupy the unit for several cycles.
    function automatic logic is_long_op(input logic [2:0] op);
        logic long_op;
        long_op = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_DIV_EN
        long_op = long_op || (op == OP_DIV) || (op == OP_DIVU);
`endif
        return long_op;
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Pipeline-side bundle of the MDU controller: E-stage request, D-stage
// hazard hint, and the busy/stall/HI/LO results.
interface mdu_ctrl_if;

    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_uses_mdu;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_val, rt_val, d_uses_mdu,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, d_uses_mdu,
        output busy, stall, hi, lo
    );

endinterface

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath. The result is captured by the
// controller on the start edge and committed after the modelled latency.
// The divider exists only when MDU_DIV_EN is defined.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div_zero
);

    logic signed [63:0] s_prod;
    logic        [63:0] u_prod;

    assign s_prod = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign u_prod = {32'd0, rs_val} * {32'd0, rt_val};

`ifdef MDU_DIV_EN
    logic [31:0] safe_rt;

    // A zero divisor is replaced so the divider never produces X; the
    // controller discards the result anyway.
    assign safe_rt = (rt_val == 32'd0) ? 32'd1 : rt_val;
`endif

    // Select the HI/LO pair for the requested op.
    always_comb begin
        // NOTE: defaults first so no path through the case infers a latch.
        hi_res   = '0;
        lo_res   = '0;
        div_zero = 1'b0;
        case (op)
            OP_MULT: begin
                hi_res = s_prod[63:32];
                lo_res = s_prod[31:0];
            end
            OP_MULTU: begin
                hi_res = u_prod[63:32];
                lo_res = u_prod[31:0];
            end
`ifdef MDU_DIV_EN
            OP_DIV: begin
                div_zero = (rt_val == 32'd0);
                lo_res   = $signed(rs_val) / $signed(safe_rt);
                hi_res   = $signed(rs_val) % $signed(safe_rt);
            end
            OP_DIVU: begin
                div_zero = (rt_val == 32'd0);
                lo_res   = rs_val / safe_rt;
                hi_res   = rs_val % safe_rt;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: accepts E-stage MDU ops, models multi-cycle mult/div
// latency with a down-counter, owns HI/LO and raises the pipeline stall.
// Define MDU_DIV_EN to include DIV/DIVU; otherwise they are no-ops.
module mdu_ctrl
    import mdu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  bus
);

    mdu_state_e  state;
    logic [3:0]  cnt;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_zero;
    logic        busy_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [31:0] hi_res;
    logic [31:0] lo_res;
    logic        div_zero;

    mdu_arith u_arith (
        .op       (bus.op),
        .rs_val   (bus.rs_val),
        .rt_val   (bus.rt_val),
        .hi_res   (hi_res),
        .lo_res   (lo_res),
        .div_zero (div_zero)
    );

    // FSM: accept ops in IDLE, count down the run states, commit HI/LO at the end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            res_hi   <= '0;
            res_lo   <= '0;
            res_zero <= 1'b0;
            busy_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                res_hi   <= hi_res;
                                res_lo   <= lo_res;
                                res_zero <= div_zero;
                                cnt      <= MUL_CYCLES;
                                busy_q   <= 1'b1;
                                state    <= ST_MUL_RUN;
                            end
`ifdef MDU_DIV_EN
                            OP_DIV, OP_DIVU: begin
                                res_hi   <= hi_res;
                                res_lo   <= lo_res;
                                res_zero <= div_zero;
                                cnt      <= DIV_CYCLES;
                                busy_q   <= 1'b1;
                                state    <= ST_DIV_RUN;
                            end
`endif
                            OP_MTHI: hi_q <= bus.rs_val;
                            OP_MTLO: lo_q <= bus.rs_val;
                            default: ;
                        endcase
                    end
                end
                ST_MUL_RUN, ST_DIV_RUN: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        // A zero divisor burns the full latency but leaves HI/LO intact.
                        if (!res_zero) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.stall = bus.d_uses_mdu & (busy_q | (bus.start & is_long_op(bus.op)));

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: start  in  1  E-stage MDU instruction valid this cycle.
REQ-004 SHALL have ports: op  in  3  MDU op: MULT, MULTU, DIV, DIVU, MTHI, MTLO (encodings in package).
REQ-005 SHALL have ports: rs_val  in  32  forwarded E-stage rs operand.
REQ-006 SHALL have ports: rt_val  in  32  forwarded E-stage rt operand.
REQ-007 SHALL have ports: d_uses_mdu  in  1  D-stage instruction is MULT/DIV/MTxx/MFHI/MFLO.
REQ-008 SHALL have ports: busy  out  1  multi-cycle operation in progress.
REQ-009 SHALL have ports: stall  out  1  freeze PC/F/D, bubble into E.
REQ-010 SHALL have ports: hi  out  32  HI register; lo  out  32  LO register.

Function
REQ-011 SHALL implement states IDLE, MUL_RUN, DIV_RUN with a 4-bit down-counter cnt.
REQ-012 SHALL, in IDLE with start=1 and op MULT/MULTU, latch operand result, load cnt=5, enter MUL_RUN next edge.
REQ-013 SHALL, in IDLE with start=1 and op DIV/DIVU, latch result, load cnt=10, enter DIV_RUN next edge.
REQ-014 SHALL decrement cnt each cycle in MUL_RUN/DIV_RUN; at cnt=1 commit latched result to HI/LO and return to IDLE on that edge.
REQ-015 SHALL assert busy exactly while state != IDLE: 5 cycles for mult, 10 for div; new hi/lo visible in first IDLE cycle.
REQ-016 SHALL compute MULT as signed 32x32->64, MULTU unsigned; HI=upper 32, LO=lower 32.
REQ-017 SHALL compute DIV signed (quotient truncates toward zero, remainder takes dividend sign), DIVU unsigned; LO=quotient, HI=remainder.
REQ-018 SHALL, on divide by zero, run the full 10-cycle busy sequence and leave HI/LO unchanged.
REQ-019 SHALL, in IDLE with start=1 and op MTHI/MTLO, write rs_val to HI/LO on that edge, no busy.
REQ-020 SHALL ignore start while busy (stall logic guarantees absence; no state change).
REQ-021 SHALL drive stall = d_uses_mdu & (busy | (start & op is MULT/MULTU/DIV/DIVU)), combinationally.
REQ-022 SHALL treat undefined op codes with start=1 as no-ops.

Reset
REQ-023 SHALL on reset force state=IDLE, cnt=0, hi=0, lo=0, busy=0, latched result=0, immediately and asynchronously.
REQ-024 SHALL on reset mid-operation abort without committing HI/LO; first post-reset start is accepted normally.

Configuration
REQ-025 SHALL use macro MDU_DIV_EN: defined -> DIV/DIVU supported per REQ-013/017/018.
REQ-026 SHALL, without MDU_DIV_EN, treat DIV/DIVU as no-ops (no busy, no stall contribution, HI/LO unchanged) and synthesize no divider.

Structure
REQ-027 SHALL place op encodings, MUL_CYCLES=5, DIV_CYCLES=10 and state encodings in shared package mdu_pkg.
REQ-028 SHALL isolate combinational multiply/divide in one sub-module mdu_arith (inputs op, rs_val, rt_val; outputs hi_res, lo_res, div_zero).

Verification
REQ-029 SHALL cover: MULT rs=0xFFFFFFFF rt=2 -> busy 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE; MULTU same -> hi=0x00000001 lo=0xFFFFFFFE.
REQ-030 SHALL cover: DIV rs=-7 rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU rs=7 rt=2 -> lo=3 hi=1.
REQ-031 SHALL cover: DIVU rt=0 with hi=0x11 lo=0x22 preset via MTHI/MTLO -> busy 10 cycles, hi=0x11 lo=0x22 after.
REQ-032 SHALL cover: MULT start with d_uses_mdu=1 -> stall=1 on start cycle and all 5 busy cycles, 0 first IDLE cycle; d_uses_mdu=0 -> stall=0 throughout.
REQ-033 SHALL cover: reset asserted in DIV_RUN cycle 4 -> busy=0, hi=lo=0 immediately; next MTLO 0x5 -> lo=0x5 next edge.
REQ-034 SHALL cover: build without MDU_DIV_EN, DIV rs=8 rt=2 -> busy and stall stay 0, hi/lo unchanged.
